// File: rtl/mtm_alu_tx_sched.sv
// rtl/mtm_alu_tx_sched.sv - round-robin packet scheduler serializing frames onto mtm_Alu sin
module mtm_alu_tx_sched #(
   parameter int NUM_REQ    = 2,
   parameter int DATA_BYTES = 8,
   parameter int FRAME_GAP  = 2,
   parameter int PKT_GAP    = 50,
   localparam int OW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [NUM_REQ-1:0]            req,
   input  logic [NUM_REQ*8*DATA_BYTES-1:0] pkt_data,
   input  logic [NUM_REQ*8-1:0]          pkt_ctl,
   output logic [NUM_REQ-1:0]            gnt,
   output logic [OW-1:0]                 owner,
   output logic                          busy,
   output logic                          done,
   output logic                          sin
);

   localparam int DW   = 8 * DATA_BYTES;
   localparam int BW   = $clog2(DATA_BYTES + 1);
   localparam int GMAX = (FRAME_GAP > PKT_GAP) ? FRAME_GAP : PKT_GAP;
   localparam int GW   = (GMAX < 2) ? 1 : $clog2(GMAX);
   localparam logic [BW-1:0] LAST_FRAME = BW'(DATA_BYTES);
   localparam logic [BW-1:0] PRE_LAST   = BW'(DATA_BYTES - 1);

   typedef enum logic [2:0] {S_IDLE, S_GRANT, S_SEND, S_GAP, S_WAIT} state_t;

   state_t          state;
   logic [OW-1:0]   ptr;
   logic [OW-1:0]   win;
   logic [OW-1:0]   ptr_nxt;
   logic [DW-1:0]   data_q;
   logic [7:0]      ctl_q;
   logic [9:0]      shreg;
   logic [9:0]      next_frame;
   logic [3:0]      bit_cnt;
   logic [BW-1:0]   byte_cnt;
   logic [GW-1:0]   gap_cnt;
   logic            last_frame;
   logic            frame_end;

   // round-robin search: first requester at or above the pointer, wrapping
   always_comb begin
      int idx;
      logic found;
      win   = '0;
      found = 1'b0;
      idx   = 0;
      for (int k = 0; k < NUM_REQ; k++) begin
         idx = int'(ptr) + k;
         if (idx >= NUM_REQ) idx = idx - NUM_REQ;
         if (!found && req[idx]) begin
            found = 1'b1;
            win   = OW'(idx);
         end
      end
      if (int'(win) == NUM_REQ - 1) ptr_nxt = '0;
      else                          ptr_nxt = win + 1'b1;
   end

   // frame after the current one: type bit, byte, stop bit (start bit is driven separately)
   always_comb begin
      last_frame = (byte_cnt == LAST_FRAME);
      if (byte_cnt == PRE_LAST) next_frame = {1'b1, ctl_q, 1'b1};
      else                      next_frame = {1'b0, data_q[DW-1 -: 8], 1'b1};
      frame_end = ((state == S_SEND) && (bit_cnt == 4'd10) && (FRAME_GAP == 0)) ||
                  ((state == S_GAP) && (int'(gap_cnt) == FRAME_GAP - 1));
   end

   // scheduler FSM; outputs are registered, so done is set one edge ahead of its cycle
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= S_IDLE;
         ptr      <= '0;
         owner    <= '0;
         gnt      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
         sin      <= 1'b1;
         bit_cnt  <= '0;
         byte_cnt <= '0;
         gap_cnt  <= '0;
         shreg    <= '0;
         data_q   <= '0;
         ctl_q    <= '0;
      end else begin
         gnt  <= '0;
         done <= 1'b0;
         case (state)
            S_IDLE: begin
               sin  <= 1'b1;
               busy <= |req;
               if (|req) begin
                  state  <= S_GRANT;
                  gnt    <= NUM_REQ'(1) << win;
                  owner  <= win;
                  ptr    <= ptr_nxt;
                  data_q <= pkt_data[int'(win)*DW +: DW];
                  ctl_q  <= pkt_ctl[int'(win)*8 +: 8];
               end
            end
            S_GRANT: begin
               state    <= S_SEND;
               byte_cnt <= '0;
               bit_cnt  <= '0;
               shreg    <= {1'b0, data_q[DW-1 -: 8], 1'b1};
               data_q   <= data_q << 8;
               sin      <= 1'b0;
            end
            S_SEND: begin
               if (bit_cnt != 4'd10) begin
                  sin     <= shreg[9];
                  shreg   <= shreg << 1;
                  bit_cnt <= bit_cnt + 1'b1;
                  if (FRAME_GAP == 0 && PKT_GAP == 0 && last_frame && bit_cnt == 4'd9)
                     done <= 1'b1;
               end else if (FRAME_GAP > 0) begin
                  state   <= S_GAP;
                  gap_cnt <= '0;
                  sin     <= 1'b1;
                  if (FRAME_GAP == 1 && PKT_GAP == 0 && last_frame)
                     done <= 1'b1;
               end
            end
            S_GAP: begin
               sin     <= 1'b1;
               gap_cnt <= gap_cnt + 1'b1;
               if (FRAME_GAP >= 2 && PKT_GAP == 0 && last_frame &&
                   int'(gap_cnt) == FRAME_GAP - 2)
                  done <= 1'b1;
            end
            S_WAIT: begin
               sin <= 1'b1;
               if (int'(gap_cnt) != PKT_GAP - 1) begin
                  gap_cnt <= gap_cnt + 1'b1;
                  if (int'(gap_cnt) == PKT_GAP - 2) done <= 1'b1;
               end else begin
                  state <= S_IDLE;
                  busy  <= 1'b0;
               end
            end
            default: state <= S_IDLE;
         endcase

         // end of a frame (stop bit or last gap cycle): next frame, packet gap, or finish
         if (frame_end) begin
            if (!last_frame) begin
               state    <= S_SEND;
               byte_cnt <= byte_cnt + 1'b1;
               bit_cnt  <= '0;
               shreg    <= next_frame;
               data_q   <= data_q << 8;
               sin      <= 1'b0;
            end else if (PKT_GAP > 0) begin
               state   <= S_WAIT;
               gap_cnt <= '0;
               sin     <= 1'b1;
               done    <= (PKT_GAP == 1);
            end else begin
               state <= S_IDLE;
               busy  <= 1'b0;
               sin   <= 1'b1;
            end
         end
      end
   end

endmodule

// File: doc/mtm_alu_tx_sched.md
Name: mtm_alu_tx_sched

Overview:
Round-robin scheduler that shares the single serial input (sin) of mtm_Alu between NUM_REQ requesters. It accepts one packet per grant, made of DATA_BYTES data bytes followed by one CTL byte. It serializes the packet into 11-bit frames on sin, then enforces an inter-packet quiet time before it serves the next requester. It sits between the stimulus/traffic sources and the ALU serial input.

Parameters:
NUM_REQ, 2, number of requesters (>=1)
DATA_BYTES, 8, data bytes per packet, sent before CTL
FRAME_GAP, 2, idle cycles (sin=1) after every frame stop bit
PKT_GAP, 50, idle cycles after the last frame gap before the next grant is possible

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  asynchronous, active-high reset
req  in  NUM_REQ  per-requester packet request, level
pkt_data  in  NUM_REQ*8*DATA_BYTES  packed data; requester i at slice i; byte 0 = most significant byte, sent first
pkt_ctl  in  NUM_REQ*8  CTL byte per requester
gnt  out  NUM_REQ  one-hot, one-cycle grant pulse
owner  out  $clog2(NUM_REQ) (min 1)  index of the last granted requester
busy  out  1  high from grant until done
done  out  1  one-cycle pulse when the packet and PKT_GAP are complete
sin  out  1  serial line to mtm_Alu

Behaviour:
- Reset values (async, while reset=1): sin=1, gnt=0, busy=0, done=0, owner=0, priority pointer=0, state=IDLE. Reset mid-packet aborts the packet immediately. sin returns to 1 and no done pulse is issued.
- Frame format, bits shifted out in order: start 0, type bit (0=data, 1=CTL), byte[7] .. byte[0], stop 1. That is 11 cycles, one bit per clock.
- States: IDLE -> GRANT -> SEND -> GAP -> (SEND | WAIT) -> IDLE.
- IDLE:
  - sin=1.
  - On a posedge with any req=1, pick the winner: the first requester with req=1 searching from the pointer upward, wrapping modulo NUM_REQ.
  - Latch that requester's pkt_data and pkt_ctl, set owner, set pointer=(winner+1) mod NUM_REQ, and go to GRANT.
- GRANT (1 cycle): gnt[winner]=1 and busy=1. The requester must drop or refresh req after seeing gnt. Input data is not sampled again.
- SEND:
  - The first cycle after GRANT drives the start bit of frame 0.
  - Frames 0..DATA_BYTES-1 carry the data bytes with type=0. Frame DATA_BYTES carries CTL with type=1.
- GAP: FRAME_GAP cycles with sin=1 after each stop bit. After the CTL frame gap, go to WAIT.
- WAIT:
  - PKT_GAP cycles with sin=1.
  - On the last WAIT cycle: done=1 and busy=1. Next state is IDLE, where busy=0.
- Timing: total cycles from GRANT to done inclusive = 1 + (DATA_BYTES+1)*(11+FRAME_GAP) + PKT_GAP. With defaults this is 1+117+50 = 168.
- Requests are ignored while busy. Held requests are arbitrated in the first IDLE cycle, so back-to-back packets have exactly one IDLE cycle between done and the next gnt.
- Simultaneous requests are resolved by the round-robin pointer only. There are no fixed priorities.
- FRAME_GAP=0 and PKT_GAP=0 are legal:
  - FRAME_GAP=0: frames are contiguous.
  - PKT_GAP=0: done is asserted on the last cycle of the last frame gap, or the last stop-bit cycle if FRAME_GAP=0.
- A requester deasserting req before its grant loses its request. No grant is generated for it.
- Frame, byte and gap counters are sized for their maximum and never wrap within a packet.

Test Plan:
1. Reset holds sin=1, gnt=0, busy=0, owner=0; release with req=0 -> all outputs stay idle for 100 cycles.
2. Single packet, req[0]=1, data=64'h0011223344556677, ctl=8'h80 -> gnt[0] pulse, then sin frames 0_0_00000000_1, then 0_0_00010001_1 … through 0_1_10000000_1, each followed by 2 ones. done arrives 168 cycles after gnt (inclusive count).
3. req=2'b11 held continuously -> grants alternate 0,1,0,1; owner follows; exactly one IDLE cycle between each done and the next gnt.
4. req[1] only after reset (pointer=0) -> gnt[1] is granted; then req=2'b11 -> the next grant goes to 0.
5. reset asserted on the 5th bit of frame 3 -> sin=1 and busy=0 asynchronously, no done; after release, req[0] restarts the packet from frame 0 with gnt[0].
6. Changing pkt_data and pkt_ctl every cycle after gnt -> the transmitted bytes equal the values present at the grant-sampling edge.
